// File: rtl/mdw_pkg.sv
// Shared types and defaults for the missing_duplicated_word engine front end.
package mdw_pkg;
  localparam int unsigned MDW_W = 5;
  localparam int unsigned MDW_N = 17;
  localparam int unsigned MDW_R = 4;

  typedef logic [MDW_W-1:0]         w_t;
  typedef logic [$clog2(MDW_N)-1:0] id_t;
  typedef logic [$clog2(MDW_R)-1:0] rid_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    ARM   = 3'd3,
    RUN   = 3'd4,
    RSP   = 3'd5
  } state_t;
endpackage

// File: rtl/mdw_rr_arb.sv
// R-way round-robin arbiter: first request at or after i_ptr, wrapping.
module mdw_rr_arb #(
  parameter int unsigned R = 4
) (
  input  logic [R-1:0]         i_req,
  input  logic [$clog2(R)-1:0] i_ptr,
  output logic [$clog2(R)-1:0] o_grant,
  output logic                 o_any
);
  localparam int unsigned RW = $clog2(R);
  localparam logic [RW:0] RV = (RW+1)'(R);

  logic [2*R-1:0] w_dbl;
  logic [RW:0]    w_j;

  // Doubling the vector turns the wrap-around search into a linear scan.
  assign w_dbl = {i_req, i_req};

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < R; k++) begin
      w_j = {1'b0, i_ptr} + (RW+1)'(k);
      if (!o_any && w_dbl[w_j]) begin
        o_any   = 1'b1;
        o_grant = (w_j >= RV) ? RW'(w_j - RV) : RW'(w_j);
      end
    end
  end
endmodule

// File: rtl/missing_duplicated_word_sched.sv
// Scheduler sharing one missing_duplicated_word engine between R requesters.
module missing_duplicated_word_sched
  import mdw_pkg::*;
#(
  parameter int unsigned W = MDW_W,
  parameter int unsigned N = MDW_N,
  parameter int unsigned R = MDW_R
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_vld,
  input  logic [R*W-1:0]       req_dat,
  output logic [R-1:0]         req_rdy,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [$clog2(R)-1:0] rsp_id,
  output logic [W-1:0]         rsp_dat,
  output logic                 eng_state_upt,
  output logic [$clog2(N)-1:0] eng_state_id,
  output logic [W-1:0]         eng_state_dat,
  output logic                 eng_cntrl_start,
  input  logic                 eng_cntrl_busy_r,
  input  logic [W-1:0]         eng_cntrl_dat_r
);
  localparam int unsigned RW = $clog2(R);
  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST  = IW'(N-1);
  localparam logic [RW-1:0] RLAST = RW'(R-1);

  state_t        r_state;
  logic [RW-1:0] r_ptr;
  logic [RW-1:0] r_grant;
  logic [IW-1:0] r_cnt;
  logic [R-1:0]  r_req_rdy;
  logic          r_rsp_vld;
  logic [RW-1:0] r_rsp_id;
  logic [W-1:0]  r_rsp_dat;
  logic          r_start;

  logic [RW-1:0] w_grant;
  logic          w_any;
  logic          w_vld_g;
  logic [W-1:0]  w_dat_g;
  logic [RW-1:0] w_ptr_nxt;
  logic [R-1:0]  w_onehot;

  mdw_rr_arb #(.R(R)) u_arb (
    .i_req   (req_vld),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_comb begin
    w_vld_g = 1'b0;
    w_dat_g = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (RW'(i) == r_grant) begin
        w_vld_g = req_vld[i];
        w_dat_g = req_dat[i*W +: W];
      end
    end
  end

  assign w_ptr_nxt = (w_grant == RLAST) ? '0 : w_grant + 1'b1;
  assign w_onehot  = {{(R-1){1'b0}}, 1'b1} << w_grant;

  // Table writes follow the granted word combinationally; the engine registers them.
  assign eng_state_upt   = (r_state == LOAD) && w_vld_g;
  assign eng_state_id    = r_cnt;
  assign eng_state_dat   = w_dat_g;
  assign eng_cntrl_start = r_start;
  assign req_rdy         = r_req_rdy;
  assign rsp_vld         = r_rsp_vld;
  assign rsp_id          = r_rsp_id;
  assign rsp_dat         = r_rsp_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_req_rdy <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_dat <= '0;
      r_start   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && !eng_cntrl_busy_r) begin
            r_grant   <= w_grant;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= '0;
            r_req_rdy <= w_onehot;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (w_vld_g) begin
            if (r_cnt == LAST) begin
              r_req_rdy <= '0;
              r_start   <= 1'b1;
              r_state   <= START;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        START: begin
          r_start <= 1'b0;
          r_state <= ARM;
        end
        // Skips one cycle so the busy-low left over from the previous scan is never seen.
        ARM: r_state <= RUN;
        RUN: begin
          if (!eng_cntrl_busy_r) begin
            r_rsp_dat <= eng_cntrl_dat_r;
            r_rsp_id  <= r_grant;
            r_rsp_vld <= 1'b1;
            r_state   <= RSP;
          end
        end
        RSP: begin
          if (rsp_rdy) begin
            r_rsp_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_rdy));
  a_start_idle: assert property (@(posedge clk) disable iff (!rst)
    eng_cntrl_start |-> !eng_cntrl_busy_r);
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst)
    (rsp_vld && !rsp_rdy) |=> (rsp_vld && $stable(rsp_id) && $stable(rsp_dat)));
endmodule
